// File: rtl/garage_door_ctrl.sv
// -----------------------------------------------------------------------------
// garage_door_ctrl
//   Garage-door controller. It sits between the debounced key/sensor inputs
//   and the motor driver / signal lamps. Features:
//     - travel-timeout watchdog that parks the controller in FAULT
//     - optional auto-close timer while the door stands open
//     - motor dead-time (PAUSE) before every direction reversal
//     - obstacle light barrier and a dedicated stop / acknowledge key
//
//   Ports
//     clk2m        in   system clock (2 MHz)
//     rst_n        in   asynchronous reset, active-low
//     key_up       in   open request (level)
//     key_down     in   close request (level)
//     key_stop     in   stop / fault acknowledge (level)
//     sense_up     in   fully-open limit switch
//     sense_down   in   fully-closed limit switch
//     obstacle     in   light-barrier interruption, active-high
//     ml           out  motor down (left)
//     mr           out  motor up (right)
//     light_red    out  red lamp
//     light_green  out  green lamp
//     fault        out  controller parked in FAULT
//     state_o      out  current state code
//
//   Parameters
//     CNT_W        width of the shared state timer
//     MOVE_TIMEOUT max cycles in UP or DOWN before FAULT (>= 1)
//     AUTO_CLOSE   cycles in OPEN before automatic close, 0 disables
//     REV_DELAY    motor-off cycles in PAUSE before reversing (>= 1)
// -----------------------------------------------------------------------------
module garage_door_ctrl #(
    parameter int CNT_W        = 26,
    parameter int MOVE_TIMEOUT = 40_000_000,
    parameter int AUTO_CLOSE   = 60_000_000,
    parameter int REV_DELAY    = 1_000_000
) (
    input  logic       clk2m,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_stop,
    input  logic       sense_up,
    input  logic       sense_down,
    input  logic       obstacle,
    output logic       ml,
    output logic       mr,
    output logic       light_red,
    output logic       light_green,
    output logic       fault,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UP     = 3'd1,
        S_OPEN   = 3'd2,
        S_DOWN   = 3'd3,
        S_CLOSED = 3'd4,
        S_PAUSE  = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Direction to resume after PAUSE; 0 matches the reset value.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // "Expiry N" fires on the edge where the timer holds N-1, so the state
    // lasts exactly N cycles. AUTO_CLOSE=0 never uses its constant.
    localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(AUTO_CLOSE - 1);
    localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(REV_DELAY - 1);
    localparam bit               CLOSE_EN   = (AUTO_CLOSE != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_dir_q, pend_dir_d;
    logic             tmr_clr;
    logic             both_limits;

    assign both_limits = sense_up & sense_down;

    // ------------------------------------------------------------------
    // State, timer and pending-direction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            pend_dir_q <= DIR_UP;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_dir_q <= pend_dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pend_dir_d = pend_dir_q;
        tmr_clr    = 1'b0;

        // Both limit switches closed at once is physically impossible, so
        // treat it as a wiring/sensor fault regardless of where we are.
        if (state_q != S_FAULT && both_limits) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_up)
                        state_d = S_UP;
                    else if (key_down)
                        state_d = S_DOWN;
                end

                S_UP: begin
                    if (sense_up)
                        state_d = S_OPEN;
                    else if (key_stop)
                        state_d = S_IDLE;
                    else if (key_down && !key_up) begin
                        state_d    = S_PAUSE;
                        pend_dir_d = DIR_DOWN;
                    end else if (timer_q == MOVE_LAST)
                        state_d = S_FAULT;
                end

                S_DOWN: begin
                    if (sense_down)
                        state_d = S_CLOSED;
                    else if (obstacle) begin
                        state_d    = S_PAUSE;
                        pend_dir_d = DIR_UP;
                    end else if (key_stop)
                        state_d = S_IDLE;
                    else if (key_up) begin
                        // up wins even when both keys are held
                        state_d    = S_PAUSE;
                        pend_dir_d = DIR_UP;
                    end else if (timer_q == MOVE_LAST)
                        state_d = S_FAULT;
                end

                S_PAUSE: begin
                    // direction keys are deliberately ignored during dead-time
                    if (key_stop)
                        state_d = S_IDLE;
                    else if (timer_q == REV_LAST)
                        state_d = (pend_dir_q == DIR_DOWN) ? S_DOWN : S_UP;
                end

                S_OPEN: begin
                    if (key_down && !obstacle)
                        state_d = S_DOWN;
                    else if (key_up || obstacle)
                        tmr_clr = 1'b1;     // restart the auto-close period
                    else if (CLOSE_EN && timer_q == CLOSE_LAST)
                        state_d = S_DOWN;
                end

                S_CLOSED: begin
                    if (key_up)
                        state_d = S_UP;
                end

                S_FAULT: begin
                    if (key_stop && !both_limits)
                        state_d = S_IDLE;
                end

                default: state_d = S_IDLE;  // unused code 7
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shared timer: cleared on state change, saturates at all-ones
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q || tmr_clr)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Moore outputs from the registered state only
    // ------------------------------------------------------------------
    assign mr          = (state_q == S_UP);
    assign ml          = (state_q == S_DOWN);
    assign light_green = (state_q == S_OPEN);
    assign light_red   = ~light_green;
    assign fault       = (state_q == S_FAULT);
    assign state_o     = state_q;

endmodule
